// File: rtl/clock_pkg.sv
// clock_pkg: shared BCD types, digit limits, FSM states and load validation for bcd_clock_core
package clock_pkg;
  typedef logic [3:0] bcd_t;
  typedef enum logic {STOP, RUN} state_t;
  localparam bcd_t SEC_MAX_TENS      = 4'd5;
  localparam bcd_t SEC_MAX_UNITS     = 4'd9;
  localparam bcd_t MIN_MAX_TENS      = 4'd5;
  localparam bcd_t MIN_MAX_UNITS     = 4'd9;
  localparam bcd_t HR_TENS_MAX       = 4'd2;
  localparam bcd_t HR_UNITS_MAX_AT_2 = 4'd3;
  localparam bcd_t UNITS_MAX         = 4'd9;
  // A loaded HHMMSS is accepted only if every digit is BCD and the time is a real 24-hour time
  function automatic logic time_valid(bcd_t h1, bcd_t h0, bcd_t m1, bcd_t m0, bcd_t s1, bcd_t s0);
    return (h1 <= HR_TENS_MAX) && ((h1 < HR_TENS_MAX) ? (h0 <= UNITS_MAX) : (h0 <= HR_UNITS_MAX_AT_2)) &&
           (m1 <= MIN_MAX_TENS) && (m0 <= MIN_MAX_UNITS) && (s1 <= SEC_MAX_TENS) && (s0 <= SEC_MAX_UNITS);
  endfunction
endpackage

// File: rtl/bcd_digit_cnt.sv
// bcd_digit_cnt: one BCD digit counting 0..MAX with clear > load > increment and a wrap carry
module bcd_digit_cnt
  import clock_pkg::*;
#(
  parameter bcd_t MAX = 4'd9
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic ld_i,
  input  bcd_t ld_val_i,
  input  logic inc_i,
  output bcd_t q_o,
  output logic carry_o
);
  bcd_t q_q, q_d;
  // Next digit value; wrapping at MAX is what raises the carry into the next digit
  always_comb q_d = clr_i ? 4'd0 : ld_i ? ld_val_i : inc_i ? ((q_q == MAX) ? 4'd0 : q_q + 4'd1) : q_q;
  // Digit register
  always_ff @(posedge clk or posedge rst)
    if (rst) q_q <= 4'd0;
    else q_q <= q_d;
  assign q_o = q_q;
  assign carry_o = inc_i & (q_q == MAX);
endmodule

// File: rtl/bcd_clock_core.sv
// bcd_clock_core: 24-hour BCD timekeeper with load validation and start/exit/reset commands; HOURLY_CHIME_EN adds the hourly chime pulse
module bcd_clock_core
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int CNT_W    = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] ld_h1,
  input  logic [3:0] ld_h0,
  input  logic [3:0] ld_m1,
  input  logic [3:0] ld_m0,
  input  logic [3:0] ld_s1,
  input  logic [3:0] ld_s0,
  input  logic       cmd_start,
  input  logic       cmd_reset,
  input  logic       cmd_exit,
  output logic [3:0] h1,
  output logic [3:0] h0,
  output logic [3:0] m1,
  output logic [3:0] m0,
  output logic [3:0] s1,
  output logic [3:0] s0,
  output logic       running,
  output logic       sec_pulse,
  output logic       load_err,
  output logic       chime
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  bcd_t h1_q, h0_q, h1_d, h0_d;
  logic sec_q, err_q, run, term, ld_ok, do_ld, ld_dig, do_exit, do_start, tick, wrap23;
  logic c_s0, c_s1, c_m0, c_m1;
  assign run      = state_q == RUN;
  assign term     = presc_q == CNT_W'(TICK_DIV - 1);
  assign ld_ok    = time_valid(ld_h1, ld_h0, ld_m1, ld_m0, ld_s1, ld_s0);
  assign do_ld    = !cmd_reset & load;
  assign ld_dig   = do_ld & ld_ok;
  assign do_exit  = !cmd_reset & !load & cmd_exit & run;
  assign do_start = !cmd_reset & !load & !cmd_exit & cmd_start & !run;
  assign tick     = !cmd_reset & !load & !cmd_exit & run & term;
  assign wrap23   = (h1_q == HR_TENS_MAX) & (h0_q == HR_UNITS_MAX_AT_2);
  // Run/stop control: clear forces STOP, exit pauses, start resumes
  always_comb state_d = (cmd_reset | do_exit) ? STOP : do_start ? RUN : state_q;
  // FSM state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= STOP;
    else state_q <= state_d;
  // Prescaler: restarts on clear/valid load/start so a full second follows, frozen when paused
  always_comb presc_d = (cmd_reset | ld_dig | do_start) ? '0 :
                        (run & !do_exit) ? (term ? '0 : presc_q + CNT_W'(1)) : presc_q;
  // Prescaler register
  always_ff @(posedge clk or posedge rst)
    if (rst) presc_q <= '0;
    else presc_q <= presc_d;
  // MM:SS digits: each stage increments only when every lower stage wraps, so all update together
  bcd_digit_cnt #(.MAX(SEC_MAX_UNITS)) u_s0 (.clk, .rst, .clr_i(cmd_reset), .ld_i(ld_dig), .ld_val_i(ld_s0), .inc_i(tick), .q_o(s0), .carry_o(c_s0));
  bcd_digit_cnt #(.MAX(SEC_MAX_TENS))  u_s1 (.clk, .rst, .clr_i(cmd_reset), .ld_i(ld_dig), .ld_val_i(ld_s1), .inc_i(c_s0), .q_o(s1), .carry_o(c_s1));
  bcd_digit_cnt #(.MAX(MIN_MAX_UNITS)) u_m0 (.clk, .rst, .clr_i(cmd_reset), .ld_i(ld_dig), .ld_val_i(ld_m0), .inc_i(c_s1), .q_o(m0), .carry_o(c_m0));
  bcd_digit_cnt #(.MAX(MIN_MAX_TENS))  u_m1 (.clk, .rst, .clr_i(cmd_reset), .ld_i(ld_dig), .ld_val_i(ld_m1), .inc_i(c_m0), .q_o(m1), .carry_o(c_m1));
  // Hour pair: units wrap at 9 except 23 rolls straight to 00
  always_comb begin
    h1_d = cmd_reset ? 4'd0 : ld_dig ? ld_h1 : !c_m1 ? h1_q : wrap23 ? 4'd0 : (h0_q == UNITS_MAX) ? h1_q + 4'd1 : h1_q;
    h0_d = cmd_reset ? 4'd0 : ld_dig ? ld_h0 : !c_m1 ? h0_q : (wrap23 | (h0_q == UNITS_MAX)) ? 4'd0 : h0_q + 4'd1;
  end
  // Hour registers and one-cycle status pulses
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      h1_q  <= 4'd0;
      h0_q  <= 4'd0;
      sec_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      h1_q  <= h1_d;
      h0_q  <= h0_d;
      sec_q <= tick;
      err_q <= do_ld & !ld_ok;
    end
  assign h1        = h1_q;
  assign h0        = h0_q;
  assign running   = run;
  assign sec_pulse = sec_q;
  assign load_err  = err_q;
`ifdef HOURLY_CHIME_EN
  logic chime_q;
  // A minute-tens carry only happens on a counted tick rolling MM:SS to 00:00
  always_ff @(posedge clk or posedge rst)
    if (rst) chime_q <= 1'b0;
    else chime_q <= c_m1;
  assign chime = chime_q;
`else
  assign chime = 1'b0;
`endif
endmodule

// File: tb/tb_bcd_clock_core.sv
// tb_bcd_clock_core: directed self-checking bench for bcd_clock_core with TICK_DIV=4
module tb_bcd_clock_core;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0, cmd_start = 1'b0, cmd_reset = 1'b0, cmd_exit = 1'b0;
  logic [3:0] ld_h1 = '0, ld_h0 = '0, ld_m1 = '0, ld_m0 = '0, ld_s1 = '0, ld_s0 = '0;
  logic [3:0] h1, h0, m1, m0, s1, s0;
  logic running, sec_pulse, load_err, chime;
  logic [23:0] t;
  int ncmp = 0, nerr = 0;
`ifdef HOURLY_CHIME_EN
  localparam logic CHIME_EXP = 1'b1;
`else
  localparam logic CHIME_EXP = 1'b0;
`endif

  bcd_clock_core #(.TICK_DIV(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .load(load),
    .ld_h1(ld_h1), .ld_h0(ld_h0), .ld_m1(ld_m1), .ld_m0(ld_m0), .ld_s1(ld_s1), .ld_s0(ld_s0),
    .cmd_start(cmd_start), .cmd_reset(cmd_reset), .cmd_exit(cmd_exit),
    .h1(h1), .h0(h0), .m1(m1), .m0(m0), .s1(s1), .s0(s0),
    .running(running), .sec_pulse(sec_pulse), .load_err(load_err), .chime(chime)
  );

  always #5 clk = ~clk;
  assign t = {h1, h0, m1, m0, s1, s0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_load(input logic [23:0] v);
    {ld_h1, ld_h0, ld_m1, ld_m0, ld_s1, ld_s0} = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic pulse_start();
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
  endtask

  task automatic pulse_exit();
    cmd_exit = 1'b1;
    step();
    cmd_exit = 1'b0;
  endtask

  task automatic pulse_reset();
    cmd_reset = 1'b1;
    step();
    cmd_reset = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    ncmp++; if ({t, running, sec_pulse, load_err, chime} !== 28'h0) begin nerr++; $display("FAIL por_state: got time=%h flags=%b%b%b%b want 000000 0000", t, running, sec_pulse, load_err, chime); end
    drive_load(24'h010203);
    pulse_start();
    repeat (4) step();
    ncmp++; if (t !== 24'h010204) begin nerr++; $display("FAIL pre_rst_time: got %h want 010204", t); end
    ncmp++; if (sec_pulse !== 1'b1) begin nerr++; $display("FAIL pre_rst_sec: got %b want 1", sec_pulse); end
    #1 rst = 1'b1;
    #1;
    ncmp++; if (t !== 24'h000000) begin nerr++; $display("FAIL async_rst_time: got %h want 000000", t); end
    ncmp++; if ({running, sec_pulse, load_err, chime} !== 4'b0000) begin nerr++; $display("FAIL async_rst_flags: got %b want 0000", {running, sec_pulse, load_err, chime}); end
    step();
    rst = 1'b0;
    step();
    ncmp++; if (running !== 1'b0) begin nerr++; $display("FAIL post_rst_stop: got %b want 0", running); end
  endtask

  task automatic test_count();
    int cnt = 0;
    pulse_reset();
    drive_load(24'h123456);
    pulse_start();
    repeat (16) begin
      step();
      cnt += int'(sec_pulse);
    end
    ncmp++; if (cnt != 4) begin nerr++; $display("FAIL count_pulses: got %0d want 4", cnt); end
    ncmp++; if (t !== 24'h123500) begin nerr++; $display("FAIL count_time: got %h want 123500", t); end
    ncmp++; if (running !== 1'b1) begin nerr++; $display("FAIL count_running: got %b want 1", running); end
    pulse_exit();
  endtask

  task automatic test_rollover();
    pulse_reset();
    drive_load(24'h235959);
    pulse_start();
    repeat (3) step();
    ncmp++; if (t !== 24'h235959 || sec_pulse !== 1'b0) begin nerr++; $display("FAIL roll_before: got %h sec=%b want 235959 sec=0", t, sec_pulse); end
    step();
    ncmp++; if (t !== 24'h000000) begin nerr++; $display("FAIL roll_time: got %h want 000000", t); end
    ncmp++; if (sec_pulse !== 1'b1) begin nerr++; $display("FAIL roll_sec: got %b want 1", sec_pulse); end
    ncmp++; if (chime !== CHIME_EXP) begin nerr++; $display("FAIL roll_chime: got %b want %b", chime, CHIME_EXP); end
    step();
    ncmp++; if (chime !== 1'b0 || sec_pulse !== 1'b0) begin nerr++; $display("FAIL roll_after: got chime=%b sec=%b want 0 0", chime, sec_pulse); end
    pulse_exit();
  endtask

  task automatic test_bad_load();
    drive_load(24'h290000);
    ncmp++; if (load_err !== 1'b1 || t !== 24'h000000) begin nerr++; $display("FAIL bad_h29: got err=%b time=%h want 1 000000", load_err, t); end
    step();
    ncmp++; if (load_err !== 1'b0) begin nerr++; $display("FAIL bad_h29_len: got %b want 0", load_err); end
    drive_load(24'h126000);
    ncmp++; if (load_err !== 1'b1 || t !== 24'h000000) begin nerr++; $display("FAIL bad_m60: got err=%b time=%h want 1 000000", load_err, t); end
    drive_load(24'h240000);
    ncmp++; if (load_err !== 1'b1 || t !== 24'h000000) begin nerr++; $display("FAIL bad_h24: got err=%b time=%h want 1 000000", load_err, t); end
    drive_load(24'h195959);
    ncmp++; if (load_err !== 1'b0 || t !== 24'h195959) begin nerr++; $display("FAIL good_195959: got err=%b time=%h want 0 195959", load_err, t); end
  endtask

  task automatic test_pause();
    pulse_reset();
    pulse_start();
    repeat (8) step();
    ncmp++; if (t !== 24'h000002) begin nerr++; $display("FAIL pause_run2: got %h want 000002", t); end
    pulse_exit();
    ncmp++; if (running !== 1'b0) begin nerr++; $display("FAIL pause_stop: got %b want 0", running); end
    for (int i = 0; i < 20; i++) begin
      step();
      ncmp++; if (t !== 24'h000002 || sec_pulse !== 1'b0) begin nerr++; $display("FAIL pause_frozen[%0d]: got %h sec=%b want 000002 sec=0", i, t, sec_pulse); end
    end
    pulse_start();
    repeat (3) step();
    ncmp++; if (t !== 24'h000002) begin nerr++; $display("FAIL resume_early: got %h want 000002", t); end
    step();
    ncmp++; if (t !== 24'h000003 || sec_pulse !== 1'b1) begin nerr++; $display("FAIL resume_tick: got %h sec=%b want 000003 sec=1", t, sec_pulse); end
  endtask

  task automatic test_collision();
    pulse_reset();
    pulse_start();
    repeat (3) step();
    drive_load(24'h080000);
    ncmp++; if (t !== 24'h080000 || sec_pulse !== 1'b0) begin nerr++; $display("FAIL load_on_tick: got %h sec=%b want 080000 sec=0", t, sec_pulse); end
    ncmp++; if (running !== 1'b1) begin nerr++; $display("FAIL load_keeps_run: got %b want 1", running); end
    repeat (3) step();
    ncmp++; if (t !== 24'h080000) begin nerr++; $display("FAIL load_presc_clr: got %h want 080000", t); end
    step();
    ncmp++; if (t !== 24'h080001 || sec_pulse !== 1'b1) begin nerr++; $display("FAIL load_next_tick: got %h sec=%b want 080001 sec=1", t, sec_pulse); end
    {ld_h1, ld_h0, ld_m1, ld_m0, ld_s1, ld_s0} = 24'h120000;
    load = 1'b1;
    cmd_reset = 1'b1;
    step();
    load = 1'b0;
    cmd_reset = 1'b0;
    ncmp++; if (t !== 24'h000000 || running !== 1'b0 || load_err !== 1'b0) begin nerr++; $display("FAIL reset_beats_load: got %h run=%b err=%b want 000000 0 0", t, running, load_err); end
  endtask

  initial begin
    test_reset();
    test_count();
    test_rollover();
    test_bad_load();
    test_pause();
    test_collision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
